// File: rtl/wb_hazard_tracker_pkg.sv
// Shared types and encodings for the writeback hazard tracker.
package wb_hazard_tracker_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 1 << ADDR_W;
  localparam int unsigned FWD_W  = 2;

  typedef logic [FWD_W-1:0] fwd_t;

  // Operand source selects.
  localparam fwd_t FWD_RF = 2'b00;
  localparam fwd_t FWD_S1 = 2'b01;
  localparam fwd_t FWD_S2 = 2'b10;
  localparam fwd_t FWD_S3 = 2'b11;

  // One in-flight pipeline stage entry.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [ADDR_W-1:0] dst;
  } stage_t;

endpackage

// File: rtl/hazard_src_cmp.sv
// Per-operand comparator: picks the youngest in-flight producer of an operand
// and flags a load that is still in execute.
module hazard_src_cmp
  import wb_hazard_tracker_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic              used,
  input  stage_t            s1,
  input  stage_t            s2,
  input  stage_t            s3,
  output fwd_t              fwd,
  output logic              load_hit
);

  // Only the execute stage can hold a not-yet-available load result.
  logic unused_loads;
  assign unused_loads = s2.load ^ s3.load;

  function automatic logic producer(input stage_t s, input logic [ADDR_W-1:0] a);
    return s.valid && s.we && (s.dst == a);
  endfunction

  // Youngest-first search; register 0 is hardwired and never forwarded.
  always_comb begin
    fwd      = FWD_RF;
    load_hit = 1'b0;
    if (used && (src != '0)) begin
      if (producer(s1, src)) begin
        load_hit = s1.load;
        fwd      = s1.load ? FWD_RF : FWD_S1;
      end else if (producer(s2, src)) begin
        fwd = FWD_S2;
      end else if (producer(s3, src)) begin
        fwd = FWD_S3;
      end
    end
  end

endmodule

// File: rtl/wb_hazard_tracker.sv
// Tracks in-flight register writes, produces load-use stall, operand forward
// selects and the register-file write port.
module wb_hazard_tracker
  import wb_hazard_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_we,
  input  logic              issue_load,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              src_a_used,
  input  logic              src_b_used,
  input  logic              flush,
  output logic              stall,
  output fwd_t              fwd_a,
  output fwd_t              fwd_b,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [NREG-1:0]   busy
);

  stage_t s1, s2, s3;
  stage_t issue_entry;
  logic   hit_a, hit_b;
  logic   accept;

  hazard_src_cmp u_cmp_a (
    .src      (src_a),
    .used     (src_a_used),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .fwd      (fwd_a),
    .load_hit (hit_a)
  );

  hazard_src_cmp u_cmp_b (
    .src      (src_b),
    .used     (src_b_used),
    .s1       (s1),
    .s2       (s2),
    .s3       (s3),
    .fwd      (fwd_b),
    .load_hit (hit_b)
  );

  // Flush overrides any load-use stall.
  assign stall  = (hit_a | hit_b) & ~flush;
  assign accept = issue_valid & ~stall & ~flush;

  // Entry built from the issuing instruction.
  always_comb begin
    issue_entry       = '0;
    issue_entry.valid = 1'b1;
    issue_entry.we    = issue_we;
    issue_entry.load  = issue_load;
    issue_entry.dst   = issue_dst;
  end

  // Stage advance; flush kills both the issuing instruction and S1 contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s3 <= s2;
      s2 <= flush  ? '0 : s1;
      s1 <= accept ? issue_entry : '0;
    end
  end

  // Pending-destination map; register 0 never marked.
  always_comb begin
    busy = '0;
    if (s1.valid && s1.we && (s1.dst != '0)) busy[s1.dst] = 1'b1;
    if (s2.valid && s2.we && (s2.dst != '0)) busy[s2.dst] = 1'b1;
    if (s3.valid && s3.we && (s3.dst != '0)) busy[s3.dst] = 1'b1;
  end

  assign wb_en   = s3.valid & s3.we;
  assign wb_addr = wb_en ? s3.dst : '0;

endmodule
